adder_stim_checker: RTL and testbench

//  Initiator/scoreboard for the registered 8-bit ripple-carry adder datapath.
//  - Generates pseudo-random operand vectors (A, B, Cin) and drives them into the adder.
//  - Latency-aligns expected results and compares them against the returned Sout/Cout.
//  - Reports pass/fail and error counts for on-board self-test.

---
 rtl/adder_stim_checker.sv | 247 ++++++++++++++++++++++++
 tb/tb_adder_stim_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adder_stim_checker.sv
// Self-test initiator/scoreboard for a registered 8-bit adder: LFSR operand generator,
// latency-aligned expected-result pipeline and result counters. Optional macro: ADDER_CHK_FIRST_ERR_EN.
module adder_stim_checker #(
    parameter int          NUM_VECTORS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic        Cin,
    input  logic [7:0]  Sout,
    input  logic        Cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] vec_count
`ifdef ADDER_CHK_FIRST_ERR_EN
    ,
    output logic [25:0] first_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] NV_C  = 16'(NUM_VECTORS);
    localparam logic [15:0] LAT_C = 16'(LATENCY);

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero state never maps to zero
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t      state_r, state_nxt_s;
    logic        launch_s;
    logic [15:0] issue_cnt_r, drain_cnt_r;
    logic [15:0] lfsr_r, vec_nxt_s;
    logic [7:0]  a_r, b_r;
    logic        cin_r;
    logic [8:0]  exp_in_s;
    logic [LATENCY-1:0] pipe_vld_r;
    logic [8:0]  pipe_exp_r [LATENCY];
    logic        tail_vld_s, mismatch_s;
    logic [15:0] err_cnt_r, vec_cnt_r, err_nxt_s, vcnt_nxt_s;
    logic        busy_r, done_r, pass_r;

    assign A         = a_r;
    assign B         = b_r;
    assign Cin       = cin_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_cnt_r;
    assign vec_count = vec_cnt_r;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; launch_s marks an accepted start
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (issue_cnt_r == NV_C) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == LAT_C) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Issue and drain counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt_r <= 16'd0;
            drain_cnt_r <= 16'd0;
        end else begin
            if (launch_s) begin
                issue_cnt_r <= 16'd1;
            end else if (state_r == ST_RUN && state_nxt_s == ST_RUN) begin
                issue_cnt_r <= issue_cnt_r + 16'd1;
            end else begin
                issue_cnt_r <= issue_cnt_r;
            end
            if (state_nxt_s == ST_DRAIN) begin
                drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 16'd1 : 16'd1;
            end else begin
                drain_cnt_r <= 16'd0;
            end
        end
    end

    // The first vector of a run is SEED itself; later ones step the LFSR
    always_comb begin
        if (state_r == ST_RUN) begin
            vec_nxt_s = lfsr_step(lfsr_r);
        end else begin
            vec_nxt_s = SEED;
        end
    end

    // Operand registers, zero whenever not in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_r <= SEED;
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            cin_r  <= 1'b0;
        end else if (state_nxt_s == ST_RUN) begin
            lfsr_r <= vec_nxt_s;
            a_r    <= vec_nxt_s[7:0];
            b_r    <= vec_nxt_s[15:8];
            cin_r  <= vec_nxt_s[0] ^ vec_nxt_s[15];
        end else begin
            lfsr_r <= lfsr_r;
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            cin_r  <= 1'b0;
        end
    end

    assign exp_in_s = {1'b0, a_r} + {1'b0, b_r} + {8'd0, cin_r};

    // Expected-result delay line, aligned with the adder latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                pipe_exp_r[i] <= 9'd0;
            end
        end else begin
            pipe_vld_r[0] <= (state_r == ST_RUN);
            pipe_exp_r[0] <= exp_in_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_exp_r[i] <= pipe_exp_r[i-1];
            end
        end
    end

    assign tail_vld_s = pipe_vld_r[LATENCY-1];
    assign mismatch_s = tail_vld_s && ({Cout, Sout} != pipe_exp_r[LATENCY-1]);

    // Count update; error count saturates
    always_comb begin
        vcnt_nxt_s = vec_cnt_r;
        err_nxt_s  = err_cnt_r;
        if (launch_s) begin
            vcnt_nxt_s = 16'd0;
            err_nxt_s  = 16'd0;
        end else if (tail_vld_s) begin
            vcnt_nxt_s = vec_cnt_r + 16'd1;
            if (mismatch_s && err_cnt_r != 16'hFFFF) begin
                err_nxt_s = err_cnt_r + 16'd1;
            end else begin
                err_nxt_s = err_cnt_r;
            end
        end else begin
            vcnt_nxt_s = vec_cnt_r;
            err_nxt_s  = err_cnt_r;
        end
    end

    // Status and count registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            vec_cnt_r <= 16'd0;
            err_cnt_r <= 16'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            vec_cnt_r <= vcnt_nxt_s;
            err_cnt_r <= err_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r    <= (state_nxt_s == ST_DONE);
            pass_r    <= (state_nxt_s == ST_DONE) && (err_nxt_s == 16'd0);
        end
    end

`ifdef ADDER_CHK_FIRST_ERR_EN
    logic [16:0] pipe_opd_r [LATENCY];
    logic [25:0] first_err_r;

    assign first_err = first_err_r;

    // Operand copies travel with the expected value so a mismatch can be reported
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_opd_r[i] <= 17'd0;
            end
        end else begin
            pipe_opd_r[0] <= {a_r, b_r, cin_r};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_opd_r[i] <= pipe_opd_r[i-1];
            end
        end
    end

    // Capture the first mismatch of a run, then freeze
    always_ff @(posedge clk) begin
        if (!reset) begin
            first_err_r <= 26'd0;
        end else if (launch_s) begin
            first_err_r <= 26'd0;
        end else if (mismatch_s && err_cnt_r == 16'd0) begin
            first_err_r <= {pipe_opd_r[LATENCY-1], Sout, Cout};
        end else begin
            first_err_r <= first_err_r;
        end
    end
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: two instances (seeds ACE1 and 01FF) each driving a
// behavioural two-stage adder that can inject faults.
module tb_adder_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, start0, reset1, start1;
    logic [7:0]  a0, b0, sout0, a1, b1, sout1;
    logic        cin0, cout0, cin1, cout1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, vec0, err1, vec1;
`ifdef ADDER_CHK_FIRST_ERR_EN
    logic [25:0] ferr0, ferr1;
`endif
    int fmode0, fmode1;   // 0 golden, 1 Sout[0] stuck 0, 2 Cout dropped, 3 vector 3 Sout=00

    adder_stim_checker #(.NUM_VECTORS(16), .LATENCY(2), .SEED(16'hACE1)) dut0 (
        .clk(clk), .reset(reset0), .start(start0), .A(a0), .B(b0), .Cin(cin0),
        .Sout(sout0), .Cout(cout0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_count(vec0)
`ifdef ADDER_CHK_FIRST_ERR_EN
        , .first_err(ferr0)
`endif
    );

    adder_stim_checker #(.NUM_VECTORS(4), .LATENCY(2), .SEED(16'h01FF)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .A(a1), .B(b1), .Cin(cin1),
        .Sout(sout1), .Cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_count(vec1)
`ifdef ADDER_CHK_FIRST_ERR_EN
        , .first_err(ferr1)
`endif
    );

    // Two-stage registered adders; the tag is the 1-based vector number within a run
    logic [8:0] s1_0, s2_0, s1_1, s2_1;
    int cyc0, t1_0, t2_0;
    always_ff @(posedge clk) begin
        s1_0 <= {1'b0, a0} + {1'b0, b0} + {8'd0, cin0};
        s2_0 <= s1_0;
        t1_0 <= busy0 ? cyc0 + 1 : 0;
        t2_0 <= t1_0;
        cyc0 <= busy0 ? cyc0 + 1 : 0;
        s1_1 <= {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};
        s2_1 <= s1_1;
    end
    assign sout0 = (fmode0 == 1) ? {s2_0[7:1], 1'b0} :
                   ((fmode0 == 3 && t2_0 == 3) ? 8'h00 : s2_0[7:0]);
    assign cout0 = (fmode0 == 2) ? 1'b0 : s2_0[8];
    assign sout1 = s2_1[7:0];
    assign cout1 = (fmode1 == 2) ? 1'b0 : s2_1[8];

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } vec_t;
    vec_t tbl[3];

    int n_vec, n_err, e;

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full run on dut0, called at a negedge; checks the operand sequence and results
    task automatic run0(input int mode, input bit hold, output int err_exp);
        logic [15:0] l;
        logic [8:0]  s;
        int bc, idx;
        fmode0 = mode;
        start0 = 1'b1;
        @(negedge clk);
        if (!hold) start0 = 1'b0;
        l = 16'hACE1; bc = 0; idx = 0; err_exp = 0;
        for (int t = 0; t < 200 && !done0; t++) begin
            if (busy0) begin
                bc++;
                if (idx < 16) begin
                    check("vec_seq", {a0, b0, cin0}, {l[7:0], l[15:8], l[0] ^ l[15]});
                    for (int j = 0; j < 3; j++)
                        if (tbl[j].idx == idx)
                            check("vec_tbl", {a0, b0, cin0}, {tbl[j].a, tbl[j].b, tbl[j].cin});
                    s = {1'b0, l[7:0]} + {1'b0, l[15:8]} + {8'd0, l[0] ^ l[15]};
                    if ((mode == 1 && s[0]) || (mode == 2 && s[8]) || (mode == 3 && idx == 2))
                        err_exp++;
                    l = nxt(l);
                    idx++;
                end
            end
            @(negedge clk);
        end
        check("done", done0, 1);
        check("busy_cycles", bc, 18);
        check("vec_count", vec0, 16);
        check("err_count", err0, err_exp);
        check("pass", pass0, err_exp == 0);
    endtask

    initial begin
        logic [15:0] l;
        logic [8:0]  s;
        int c;
        tbl[0] = '{0, 8'hE1, 8'hAC, 1'b0};
        tbl[1] = '{1, 8'hC3, 8'h59, 1'b1};
        tbl[2] = '{2, 8'h87, 8'hB3, 1'b0};
        n_vec = 0; n_err = 0;
        fmode0 = 0; fmode1 = 0;
        reset0 = 1'b0; reset1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", {busy0, done0, pass0, cin0}, 0);
        check("rst_counts", {err0, vec0}, 0);
        check("rst_ops", {a0, b0}, 0);
        reset0 = 1'b1; reset1 = 1'b1;
        @(negedge clk);

        // golden run, then Sout[0] stuck and Cout dropped
        run0(0, 1'b0, e);
        run0(1, 1'b0, e);
        run0(2, 1'b0, e);

        // reset mid-run aborts; a restart replays from SEED
        fmode0 = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", busy0, 1);
        reset0 = 1'b0;
        @(negedge clk);
        reset0 = 1'b1;
        check("abort_flags", {busy0, done0, pass0, cin0}, 0);
        check("abort_counts", {err0, vec0}, 0);
        check("abort_ops", {a0, b0}, 0);
        run0(0, 1'b0, e);

        // start held through RUN is ignored; in DONE it restarts once
        run0(0, 1'b1, e);
        @(negedge clk);
        check("restart_busy", busy0, 1);
        check("restart_done", done0, 0);
        check("restart_counts", {err0, vec0}, 0);
        check("restart_seed", {a0, b0, cin0}, {8'hE1, 8'hAC, 1'b0});
        start0 = 1'b0;
        for (int t = 0; t < 100 && !done0; t++) @(negedge clk);
        check("rerun_done", done0, 1);
        check("rerun_vec", vec0, 16);

`ifdef ADDER_CHK_FIRST_ERR_EN
        run0(3, 1'b0, e);
        check("first_err", ferr0, {8'h87, 8'hB3, 1'b0, 8'h00, 1'b1});
        run0(0, 1'b0, e);
        check("first_err_clr", ferr0, 0);
`endif

        // SEED 01FF: first vector FF+01+1 carries out
        for (int m = 0; m < 2; m++) begin
            fmode1 = (m == 0) ? 0 : 2;
            l = 16'h01FF; c = 0;
            for (int i = 0; i < 4; i++) begin
                s = {1'b0, l[7:0]} + {1'b0, l[15:8]} + {8'd0, l[0] ^ l[15]};
                if (m == 1 && s[8]) c++;
                l = nxt(l);
            end
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("s01ff_vec0", {a1, b1, cin1}, {8'hFF, 8'h01, 1'b1});
            for (int t = 0; t < 100 && !done1; t++) @(negedge clk);
            check("s01ff_done", done1, 1);
            check("s01ff_vec", vec1, 4);
            check("s01ff_err", err1, c);
            check("s01ff_errpos", (err1 != 16'd0), m == 1);
            check("s01ff_pass", pass1, m == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
